// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage MIPS pipeline. It drives the
// PC write enable and the IF/ID and ID/EX pipe-register enables and flushes.
//   - Load-use hazards are resolved by holding PC and IF/ID while a bubble is
//     pushed into ID/EX for LOAD_STALLS cycles.
//   - A taken branch or jr resolved in EX squashes both younger stages.
//   - A jump decoded in ID squashes the instruction in IF.
//   - Data-memory busy freezes the front end; an interrupted load-use stall
//     resumes where it left off once memory is ready again.
//
// Parameters:
//   LOAD_STALLS  bubble cycles per load-use hazard (1..7)
//   CNT_WIDTH    width of the performance counters
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt as a source
//   id_jump             j/jal decoded in ID
//   ex_mem_read, ex_rt  EX holds a load writing register ex_rt
//   ex_branch_taken     branch in EX is taken
//   ex_jr               jr in EX
//   mem_busy            data memory not ready this cycle
//   pc_enable           PC load enable
//   if_id_enable/flush  IF/ID enable and nop-insert
//   id_ex_enable/flush  ID/EX enable and bubble-insert
//   stall_active        PC held this cycle
//   stall_cycles        count of cycles with PC held
//   flush_events        count of redirects (branch, jr, jump)
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, stall_cycles/flush_events are real
//                       counters; otherwise both read 0 and no flops exist.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALLS = 1,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rt,
    input  logic                 id_jump,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rt,
    input  logic                 ex_branch_taken,
    input  logic                 ex_jr,
    input  logic                 mem_busy,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_enable,
    output logic                 id_ex_flush,
    output logic                 stall_active,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Remaining bubbles after the detection cycle itself.
    localparam logic [2:0] LS_INIT = 3'(LOAD_STALLS - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use, redirect, in_lu, flush_evt;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign redirect = ex_branch_taken || ex_jr;

    // MEM_WAIT keeps the stall count, so a nonzero count means an interrupted
    // load-use stall that must resume as soon as memory is ready.
    assign in_lu = (state_q == LU_STALL) ||
                   ((state_q == MEM_WAIT) && (cnt_q != 3'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_enable = 1'b1;
        id_ex_flush  = 1'b0;
        flush_evt    = 1'b0;

        if (mem_busy) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_enable = 1'b0;
            state_d      = MEM_WAIT;
        end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_evt   = 1'b1;
            state_d     = RUN;
            cnt_d       = 3'd0;
        end else if (in_lu) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            cnt_d        = cnt_q - 3'd1;
            state_d      = (cnt_q == 3'd1) ? RUN : LU_STALL;
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
            if (LOAD_STALLS > 1) begin
                state_d = LU_STALL;
                cnt_d   = LS_INIT;
            end else begin
                state_d = RUN;
            end
        end else if (id_jump) begin
            if_id_flush = 1'b1;
            flush_evt   = 1'b1;
            state_d     = RUN;
        end else begin
            state_d = RUN;
        end

        // Reset forces a transparent pipeline regardless of state or inputs.
        if (reset) begin
            pc_enable    = 1'b1;
            if_id_enable = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_enable = 1'b1;
            id_ex_flush  = 1'b0;
            flush_evt    = 1'b0;
        end
    end

    assign stall_active = ~pc_enable;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_enable) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_evt)  flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`else
    logic unused_flush_evt;
    assign unused_flush_evt = flush_evt;
    assign stall_cycles     = '0;
    assign flush_events     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Three controllers (LOAD_STALLS = 1, 2, 3) share one stimulus stream; each
// check targets the instance selected by 'sel'. Single-cycle behaviour comes
// from a vector table; multi-cycle corner cases are hand-written sequences.
// Expected control outputs are queued when stimulus is driven and compared on
// the following falling edge. Output bundle order:
//   {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
//    stall_active}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CW = 16;

    localparam logic [5:0] NORM  = 6'b110100;
    localparam logic [5:0] STALL = 6'b000111;
    localparam logic [5:0] REDIR = 6'b111110;
    localparam logic [5:0] JUMP  = 6'b111100;
    localparam logic [5:0] BUSY  = 6'b000001;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, ex_jr, mem_busy;

    logic [5:0]    outs [3];
    logic [CW-1:0] sc   [3];
    logic [CW-1:0] fe   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic          pc_e, ifid_e, ifid_f, idex_e, idex_f, st;
        logic [CW-1:0] scv, fev;

        pipeline_hazard_ctrl #(.LOAD_STALLS(g + 1), .CNT_WIDTH(CW)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .id_rs          (id_rs),
            .id_rt          (id_rt),
            .id_uses_rt     (id_uses_rt),
            .id_jump        (id_jump),
            .ex_mem_read    (ex_mem_read),
            .ex_rt          (ex_rt),
            .ex_branch_taken(ex_branch_taken),
            .ex_jr          (ex_jr),
            .mem_busy       (mem_busy),
            .pc_enable      (pc_e),
            .if_id_enable   (ifid_e),
            .if_id_flush    (ifid_f),
            .id_ex_enable   (idex_e),
            .id_ex_flush    (idex_f),
            .stall_active   (st),
            .stall_cycles   (scv),
            .flush_events   (fev)
        );

        assign outs[g] = {pc_e, ifid_e, ifid_f, idex_e, idex_f, st};
        assign sc[g]   = scv;
        assign fe[g]   = fev;
    end

    typedef struct {
        logic       mb, br, jr, jmp, mr;
        logic [4:0] ert, rs, rt;
        logic       urt;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl [16];
    logic [5:0] exp_q [$];
    string      name_q [$];
    int         sel = 0;
    int         total = 0;
    int         bad = 0;

    function automatic vec_t mk(logic mb, logic br, logic jr, logic jmp, logic mr,
                                logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                                logic urt, logic [5:0] exp);
        vec_t v;
        v.mb = mb; v.br = br; v.jr = jr; v.jmp = jmp; v.mr = mr;
        v.ert = ert; v.rs = rs; v.rt = rt; v.urt = urt; v.exp = exp;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        mem_busy        = v.mb;
        ex_branch_taken = v.br;
        ex_jr           = v.jr;
        id_jump         = v.jmp;
        ex_mem_read     = v.mr;
        ex_rt           = v.ert;
        id_rs           = v.rs;
        id_rt           = v.rt;
        id_uses_rt      = v.urt;
    endtask

    task automatic check_out();
        logic [5:0] e;
        string      nm;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got=%b want=<queued value>", outs[sel]);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (outs[sel] !== e) begin
                bad++;
                $display("FAIL %s (dut%0d): got=%b want=%b", nm, sel, outs[sel], e);
            end
        end
    endtask

    // Drive one cycle of stimulus, compare mid-cycle, then advance past the edge.
    task automatic step(input vec_t v, input string nm);
        set_in(v);
        exp_q.push_back(v.exp);
        name_q.push_back(nm);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string nm, input int exp_sc, input int exp_fe);
        logic [CW-1:0] want_sc, want_fe;
`ifdef HAZARD_PERF_CNT_EN
        want_sc = CW'(exp_sc);
        want_fe = CW'(exp_fe);
`else
        want_sc = '0;
        want_fe = '0;
`endif
        total++;
        if (sc[sel] !== want_sc) begin
            bad++;
            $display("FAIL %s_stall_cycles (dut%0d): got=%0d want=%0d", nm, sel, sc[sel], want_sc);
        end
        total++;
        if (fe[sel] !== want_fe) begin
            bad++;
            $display("FAIL %s_flush_events (dut%0d): got=%0d want=%0d", nm, sel, fe[sel], want_fe);
        end
    endtask

    // Hold reset for one edge with hazard inputs present; outputs must stay transparent.
    task automatic do_reset(input string nm);
        reset = 1'b1;
        set_in(mk(0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0, NORM));
        exp_q.push_back(NORM);
        name_q.push_back(nm);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM));
    endtask

    initial begin
        //           mb br jr jp mr ert    rs     rt     urt exp
        tbl[0]  = mk(0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, NORM);
        tbl[1]  = mk(0, 0, 0, 0, 1, 5'd8,  5'd8,  5'd0,  0, STALL);
        tbl[2]  = mk(0, 0, 0, 0, 0, 5'd8,  5'd8,  5'd0,  0, NORM);
        tbl[3]  = mk(0, 0, 0, 0, 1, 5'd9,  5'd3,  5'd9,  1, STALL);
        tbl[4]  = mk(0, 0, 0, 0, 1, 5'd9,  5'd3,  5'd9,  0, NORM);
        tbl[5]  = mk(0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  1, NORM);
        tbl[6]  = mk(0, 0, 0, 0, 0, 5'd8,  5'd8,  5'd8,  1, NORM);
        tbl[7]  = mk(0, 0, 0, 1, 1, 5'd0,  5'd0,  5'd0,  1, JUMP);
        tbl[8]  = mk(0, 1, 0, 0, 0, 5'd0,  5'd1,  5'd2,  1, REDIR);
        tbl[9]  = mk(0, 0, 1, 0, 0, 5'd0,  5'd1,  5'd2,  1, REDIR);
        tbl[10] = mk(0, 0, 1, 0, 1, 5'd8,  5'd8,  5'd0,  0, REDIR);
        tbl[11] = mk(0, 0, 0, 1, 1, 5'd31, 5'd31, 5'd0,  0, STALL);
        tbl[12] = mk(1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, BUSY);
        tbl[13] = mk(0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, NORM);
        tbl[14] = mk(1, 0, 0, 0, 1, 5'd8,  5'd8,  5'd0,  0, BUSY);
        tbl[15] = mk(0, 0, 0, 1, 0, 5'd0,  5'd0,  5'd0,  0, JUMP);

        reset = 1'b1;
        set_in(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM));

        // Reset state and single-cycle behaviour on the LOAD_STALLS=1 instance.
        sel = 0;
        do_reset("reset_outputs");
        check_cnt("reset", 0, 0);
        for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("vec%0d", i));

        // One-cycle load-use stall.
        sel = 0;
        do_reset("reset_a");
        step(mk(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL), "lu1_stall");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM),  "lu1_resume");
        check_cnt("lu1", 1, 0);

        // Three-cycle load-use stall.
        sel = 2;
        do_reset("reset_b");
        step(mk(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL), "lu3_c1");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, STALL), "lu3_c2");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, STALL), "lu3_c3");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM),  "lu3_resume");
        check_cnt("lu3", 3, 0);

        // Taken branch while two stall cycles remain.
        sel = 2;
        do_reset("reset_c");
        step(mk(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL), "br_stall");
        step(mk(0, 1, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, REDIR), "br_redirect");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM),  "br_after1");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM),  "br_after2");
        check_cnt("br", 1, 1);

        // Memory busy for four cycles in the middle of a two-cycle stall.
        sel = 1;
        do_reset("reset_d");
        step(mk(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL), "mb_stall");
        for (int i = 0; i < 4; i++)
            step(mk(1, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, BUSY), $sformatf("mb_busy%0d", i));
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, STALL), "mb_resume_stall");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM),  "mb_run");
        check_cnt("mb", 6, 0);

        // Jump with a load to $zero in EX: no stall.
        sel = 0;
        do_reset("reset_e");
        step(mk(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, JUMP), "jmp_zero");
        step(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM), "jmp_after");
        check_cnt("jmp", 0, 1);

        // Reset in the middle of a three-cycle stall aborts it.
        sel = 2;
        do_reset("reset_f");
        step(mk(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, STALL), "rst_c1");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, STALL), "rst_c2");
        check_cnt("rst_pre", 2, 0);
        do_reset("rst_mid");
        check_cnt("rst_post", 0, 0);
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM), "rst_run1");
        step(mk(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0, NORM), "rst_run2");
        check_cnt("rst_end", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
